// File: rtl/clock_div_select.sv
`default_nettype none
// ============================================================================
// Module : clock_div_select
// Brief  : Programmable 50%-duty clock divider with glitch-free, handshaked
//          reconfiguration that swaps ratio/polarity only at period boundaries.
// Rev    : 1.0 - initial release
// ============================================================================
module clock_div_select #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_inv,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             running
);

    localparam logic [1:0]       c_ST_STOP = 2'd0;
    localparam logic [1:0]       c_ST_RUN  = 2'd1;
    localparam logic [1:0]       c_ST_PEND = 2'd2;
    localparam logic [DIV_W-1:0] c_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_ZERO    = '0;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ph;
    logic [DIV_W-1:0] r_cur_div;
    logic             r_cur_inv;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend_inv;
    logic             r_clk_out;
    logic             r_rise;

    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_ph_nxt;
    logic [DIV_W-1:0] w_cur_div_nxt;
    logic             w_cur_inv_nxt;
    logic [DIV_W-1:0] w_pend_div_nxt;
    logic             w_pend_inv_nxt;
    logic             w_clk_nxt;
    logic             w_accept;
    logic             w_last;

    always_comb begin
        w_accept       = cfg_valid && (r_state != c_ST_PEND);
        w_last         = (r_cnt == (r_cur_div - c_ONE));
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ph_nxt       = r_ph;
        w_cur_div_nxt  = r_cur_div;
        w_cur_inv_nxt  = r_cur_inv;
        w_pend_div_nxt = r_pend_div;
        w_pend_inv_nxt = r_pend_inv;

        case (r_state)
            c_ST_STOP: begin
                if (w_accept) begin
                    w_cur_div_nxt = cfg_div;
                    w_cur_inv_nxt = cfg_inv;
                    w_cnt_nxt     = c_ZERO;
                    w_ph_nxt      = 1'b0;
                    w_state_nxt   = (cfg_div != c_ZERO) ? c_ST_RUN : c_ST_STOP;
                end
            end
            c_ST_RUN: begin
                if (w_last) begin
                    w_cnt_nxt = c_ZERO;
                    w_ph_nxt  = ~r_ph;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
                // Active ratio keeps running; new config waits for a boundary
                if (w_accept) begin
                    w_pend_div_nxt = cfg_div;
                    w_pend_inv_nxt = cfg_inv;
                    w_state_nxt    = c_ST_PEND;
                end
            end
            c_ST_PEND: begin
                // Swapping as ph falls keeps every level at least min(old,new) long
                if (w_last && r_ph) begin
                    w_cur_div_nxt = r_pend_div;
                    w_cur_inv_nxt = r_pend_inv;
                    w_cnt_nxt     = c_ZERO;
                    w_ph_nxt      = 1'b0;
                    w_state_nxt   = (r_pend_div != c_ZERO) ? c_ST_RUN : c_ST_STOP;
                end else if (w_last) begin
                    w_cnt_nxt = c_ZERO;
                    w_ph_nxt  = ~r_ph;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_STOP;
            end
        endcase

        w_clk_nxt = w_ph_nxt ^ w_cur_inv_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= c_ST_STOP;
            r_cnt      <= c_ZERO;
            r_ph       <= 1'b0;
            r_cur_div  <= c_ZERO;
            r_cur_inv  <= 1'b0;
            r_pend_div <= c_ZERO;
            r_pend_inv <= 1'b0;
            r_clk_out  <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ph       <= w_ph_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_cur_inv  <= w_cur_inv_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend_inv <= w_pend_inv_nxt;
            r_clk_out  <= w_clk_nxt;
            r_rise     <= w_clk_nxt & ~r_clk_out;
        end
    end

    assign clk_out    = r_clk_out;
    assign rise_pulse = r_rise;
    assign cfg_ready  = (r_state != c_ST_PEND);
    assign running    = (r_state == c_ST_RUN) || (r_state == c_ST_PEND);

endmodule
`default_nettype wire

// File: tb/tb_clock_div_select.sv
`default_nettype none
// ============================================================================
// Module : tb_clock_div_select
// Brief  : Directed self-checking bench for clock_div_select (DIV_W=8 and 4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_clock_div_select;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_inv;
    logic       a_cfg_ready;
    logic       a_clk_out;
    logic       a_rise;
    logic       a_running;

    logic       b_cfg_valid;
    logic [3:0] b_cfg_div;
    logic       b_cfg_inv;
    logic       b_cfg_ready;
    logic       b_clk_out;
    logic       b_rise;
    logic       b_running;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    clock_div_select #(.DIV_W(8)) u_dut_a (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (a_cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_inv    (cfg_inv),
        .clk_out    (a_clk_out),
        .rise_pulse (a_rise),
        .running    (a_running)
    );

    clock_div_select #(.DIV_W(4)) u_dut_b (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg_valid  (b_cfg_valid),
        .cfg_ready  (b_cfg_ready),
        .cfg_div    (b_cfg_div),
        .cfg_inv    (b_cfg_inv),
        .clk_out    (b_clk_out),
        .rise_pulse (b_rise),
        .running    (b_running)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One edge of DUT A, then check all four observable outputs
    task automatic cyc(input string tag, input logic e_clk, input logic e_rise,
                       input logic e_rdy, input logic e_run);
        step();
        chk({tag, ".clk"},  a_clk_out,   e_clk);
        chk({tag, ".rise"}, a_rise,      e_rise);
        chk({tag, ".rdy"},  a_cfg_ready, e_rdy);
        chk({tag, ".run"},  a_running,   e_run);
    endtask

    // Vectors read chronologically from bit n-1 down to bit 0
    task automatic run_seq(input string tag, input int n, input logic [31:0] vc,
                           input logic [31:0] vr, input logic [31:0] vy, input logic [31:0] vn);
        for (int i = 0; i < n; i++) begin
            cyc($sformatf("%s%0d", tag, i), vc[n-1-i], vr[n-1-i], vy[n-1-i], vn[n-1-i]);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_div     = 8'd0;
        cfg_inv     = 1'b0;
        b_cfg_valid = 1'b0;
        b_cfg_div   = 4'd0;
        b_cfg_inv   = 1'b0;

        // Reset state
        step();
        cyc("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst.b_rdy", b_cfg_ready, 1'b1);
        chk("rst.b_clk", b_clk_out, 1'b0);
        rst = 1'b0;

        // div=2 inv=0: 0,0,1,1 repeating
        cfg_valid = 1'b1; cfg_div = 8'd2; cfg_inv = 1'b0;
        cyc("d2.load", 1'b0, 1'b0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        run_seq("d2.", 8, 32'b01100110, 32'b01000100, 32'b11111111, 32'b11111111);

        // Mid-low-phase accept of div=3 inv=1; div=7 offered in PEND is ignored
        cfg_valid = 1'b1; cfg_div = 8'd3; cfg_inv = 1'b1;
        cyc("d3.acc", 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_div = 8'd7; cfg_inv = 1'b0;
        cyc("d3.p0", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("d3.p1", 1'b1, 1'b0, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        cyc("d3.swap", 1'b1, 1'b0, 1'b1, 1'b1);
        run_seq("d3.", 7, 32'b1100011, 32'b0000010, 32'b1111111, 32'b1111111);

        // Reset while PEND with ph=1 drops the pending config
        cfg_valid = 1'b1; cfg_div = 8'd4; cfg_inv = 1'b0;
        cyc("pr.acc", 1'b1, 1'b0, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        cyc("pr.ph1", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd9;
        cyc("pr.rst", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; cfg_valid = 1'b0;
        run_seq("pr.", 6, 32'b000000, 32'b000000, 32'b111111, 32'b000000);

        // div=4 then div=0: finish the period, hold low, stop
        cfg_valid = 1'b1; cfg_div = 8'd4; cfg_inv = 1'b0;
        cyc("d4.load", 1'b0, 1'b0, 1'b1, 1'b1);
        cfg_div = 8'd0;
        cyc("d4.acc0", 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        run_seq("d4.", 11, 32'b00111100000, 32'b00100000000,
                32'b00000011111, 32'b11111100000);

        // Accept coinciding with a div=1 boundary: div=5 applies one period later
        cfg_valid = 1'b1; cfg_div = 8'd1; cfg_inv = 1'b0;
        cyc("d1.load", 1'b0, 1'b0, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        cyc("d1.c1", 1'b1, 1'b1, 1'b1, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd5;
        cyc("d1.acc", 1'b0, 1'b0, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        cyc("d1.c3", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("d1.swap", 1'b0, 1'b0, 1'b1, 1'b1);
        run_seq("d5.", 10, 32'b0000111110, 32'b0000100000,
                32'b1111111111, 32'b1111111111);

        // STOP load with div=0 inv=1 raises clk_out with a rise pulse
        rst = 1'b1;
        cyc("iv.rst", 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        cfg_valid = 1'b1; cfg_div = 8'd0; cfg_inv = 1'b1;
        cyc("iv.load", 1'b1, 1'b1, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        cyc("iv.hold", 1'b1, 1'b0, 1'b1, 1'b0);

        // DIV_W=4, div=15: period 30 without counter wrap
        b_cfg_valid = 1'b1; b_cfg_div = 4'd15; b_cfg_inv = 1'b0;
        step();
        b_cfg_valid = 1'b0;
        chk("w15.clk1", b_clk_out, 1'b0);
        chk("w15.run1", b_running, 1'b1);
        for (int k = 2; k <= 60; k++) begin
            step();
            chk($sformatf("w15.clk%0d", k), b_clk_out, ((k - 1) / 15) % 2);
            chk($sformatf("w15.rise%0d", k), b_rise, (k == 16 || k == 46) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
